// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and defaults for the I/D memory arbiter.
package riscv_mem_arbiter_pkg;

  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_REQ  = 2'b01,
    ARB_RESP = 2'b10
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Bundles the fetch port, load/store port and memory bus of the arbiter.
// slave: arbiter view. master: core + memory view (testbench / wrapper).
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              err_spurious;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, err_spurious
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, err_spurious
  );
endinterface

// File: rtl/riscv_arb_pick.sv
// Winner select for the I/D arbiter.
// Default: D beats I unless the fetch side is starved.
// RISCV_ARB_RR_EN: on a tie the port that lost the previous arbitration wins.
module riscv_arb_pick
  import riscv_mem_arbiter_pkg::*;
(
  input  logic      i_req,
  input  logic      d_req,
  input  arb_port_t last_winner,
  input  logic      starve_sat,
  output arb_port_t winner
);

`ifdef RISCV_ARB_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic pick_i;

  // I wins when alone, when starved, or in round-robin when D took the last one
  assign pick_i = i_req & (~d_req | starve_sat | (RR & (last_winner == PORT_D)));
  assign winner = pick_i ? PORT_I : PORT_D;

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares a single-ported memory between fetch (I) and load/store (D).
// One transaction in flight: latch winner in IDLE, hold until mem_gnt,
// route the read beat back to the owner. Policy lives in riscv_arb_pick
// (RISCV_ARB_RR_EN selects round-robin there).
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic                clk,
  input logic                rst,
  riscv_mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state, state_nxt;
  arb_port_t         owner, last_winner, winner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     starve_cnt;
  logic              starve_sat;
  logic              err_q;
  logic              arb_go;

  assign arb_go     = (state == ARB_IDLE) & (bus.i_req | bus.d_req);
  assign starve_sat = (starve_cnt == CW'(STARVE_LIMIT));

  riscv_arb_pick u_pick (
    .i_req       (bus.i_req),
    .d_req       (bus.d_req),
    .last_winner (last_winner),
    .starve_sat  (starve_sat),
    .winner      (winner)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  // next state: writes finish at the grant, reads take one response cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (arb_go) state_nxt = ARB_REQ;
      ARB_REQ:  if (bus.mem_gnt) state_nxt = we_q ? ARB_IDLE : ARB_RESP;
      ARB_RESP: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // latch the winning request and track fetch starvation at arbitration time
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= PORT_I;
      last_winner <= PORT_D;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      starve_cnt  <= '0;
    end else if (arb_go) begin
      owner       <= winner;
      last_winner <= winner;
      if (winner == PORT_D) begin
        we_q    <= bus.d_we;
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
      end else begin
        we_q    <= 1'b0;
        addr_q  <= bus.i_addr;
        wdata_q <= '0;
      end
      if (winner == PORT_I)              starve_cnt <= '0;
      else if (bus.i_req && !starve_sat) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // sticky flag: read data arriving when no read is waiting for it
  always_ff @(posedge clk) begin
    if (rst)                                       err_q <= 1'b0;
    else if (bus.mem_rvalid && state != ARB_RESP)  err_q <= 1'b1;
  end

  // outputs: grant and response qualified by owner; rdata zeroed for non-owner
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.i_gnt    = 1'b0;
    bus.d_gnt    = 1'b0;
    bus.i_rvalid = 1'b0;
    bus.d_rvalid = 1'b0;
    bus.i_rdata  = '0;
    bus.d_rdata  = '0;
    case (state)
      ARB_REQ: begin
        bus.mem_req = 1'b1;
        bus.i_gnt   = bus.mem_gnt & (owner == PORT_I);
        bus.d_gnt   = bus.mem_gnt & (owner == PORT_D);
      end
      ARB_RESP: begin
        bus.i_rvalid = bus.mem_rvalid & (owner == PORT_I);
        bus.d_rvalid = bus.mem_rvalid & (owner == PORT_D);
        if (owner == PORT_I) bus.i_rdata = bus.mem_rdata;
        else                 bus.d_rdata = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  assign bus.mem_we       = we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.err_spurious = err_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed cases plus randomized traffic
// scored against a transaction-level model (cycle arithmetic + queues).
module tb_riscv_mem_arbiter;
  import riscv_mem_arbiter_pkg::*;

  localparam int AW = 30, DW = 32, LIM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_req"},   64'(bus.mem_req),   64'(0));
    chk({tag, "_mem_we"},    64'(bus.mem_we),    64'(0));
    chk({tag, "_mem_addr"},  64'(bus.mem_addr),  64'(0));
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
    chk({tag, "_gnt"},       64'({bus.i_gnt, bus.d_gnt}), 64'(0));
    chk({tag, "_rvalid"},    64'({bus.i_rvalid, bus.d_rvalid}), 64'(0));
    chk({tag, "_rdata"},     64'({bus.i_rdata, bus.d_rdata}), 64'(0));
    chk({tag, "_err"},       64'(bus.err_spurious), 64'(0));
  endtask

  // memory contents: mem is what the bench memory serves, ref_mem the model's view
  logic [DW-1:0] mem [16];
  logic [DW-1:0] ref_mem [16];

  // model + environment state, continuous across runs
  int            cyc = 0, free_at = 0, req_from = 0, resp_cyc = -1;
  bit            t_act = 0, t_we = 0, i_done = 0, d_done = 0, rv_next = 0;
  arb_port_t     t_own = PORT_I, r_own = PORT_I, m_last = PORT_D;
  int            m_starve = 0;
  logic [AW-1:0] t_addr = '0, r_addr = '0, rd_addr = '0;
  logic [DW-1:0] t_wdata = '0;
  arb_port_t     win_q[$];
  int            dg_cyc[$];

  function automatic arb_port_t model_pick(bit ir, bit dr);
    if (!dr) return PORT_I;
    if (!ir) return PORT_D;
`ifdef RISCV_ARB_RR_EN
    return (m_last == PORT_I) ? PORT_D : PORT_I;
`else
    return (m_starve >= LIM) ? PORT_I : PORT_D;
`endif
  endfunction

  // ip/dp: chance of a new request per idle requester, wp: store chance, gp: mem_gnt chance
  task automatic run(input int n, input int ip, input int dp, input int wp, input int gp);
    bit exp_req, exp_ir, exp_dr;
    for (int k = 0; k < n; k++) begin
      if (i_done) bus.i_req = 1'b0;
      if (d_done) bus.d_req = 1'b0;
      i_done = 0; d_done = 0;
      if (!bus.i_req && $urandom_range(99) < ip) begin
        bus.i_req = 1'b1; bus.i_addr = AW'($urandom_range(15));
      end
      if (!bus.d_req && $urandom_range(99) < dp) begin
        bus.d_req = 1'b1; bus.d_we = ($urandom_range(99) < wp);
        bus.d_addr = AW'($urandom_range(15)); bus.d_wdata = $urandom;
      end
      bus.mem_gnt    = ($urandom_range(99) < gp);
      bus.mem_rvalid = rv_next;
      bus.mem_rdata  = rv_next ? mem[rd_addr[3:0]] : $urandom;
      rv_next = 0;
      // model: a new transaction starts once the previous one has retired
      if (!t_act && cyc >= free_at && (bus.i_req || bus.d_req)) begin
        t_own   = model_pick(bus.i_req, bus.d_req);
        t_we    = (t_own == PORT_D) ? bus.d_we : 1'b0;
        t_addr  = (t_own == PORT_D) ? bus.d_addr : bus.i_addr;
        t_wdata = bus.d_wdata;
        if (t_own == PORT_I) m_starve = 0;
        else if (bus.i_req && m_starve < LIM) m_starve++;
        m_last   = t_own;
        t_act    = 1;
        req_from = cyc + 1;
      end
      #1;
      exp_req = t_act && cyc >= req_from;
      chk("mem_req", 64'(bus.mem_req), 64'(exp_req));
      if (exp_req) begin
        chk("mem_addr", 64'(bus.mem_addr), 64'(t_addr));
        chk("mem_we", 64'(bus.mem_we), 64'(t_we));
        if (t_we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(t_wdata));
      end
      chk("i_gnt", 64'(bus.i_gnt), 64'(exp_req && bus.mem_gnt && t_own == PORT_I));
      chk("d_gnt", 64'(bus.d_gnt), 64'(exp_req && bus.mem_gnt && t_own == PORT_D));
      exp_ir = (cyc == resp_cyc) && r_own == PORT_I;
      exp_dr = (cyc == resp_cyc) && r_own == PORT_D;
      chk("i_rvalid", 64'(bus.i_rvalid), 64'(exp_ir));
      chk("d_rvalid", 64'(bus.d_rvalid), 64'(exp_dr));
      chk("i_rdata", 64'(bus.i_rdata), exp_ir ? 64'(ref_mem[r_addr[3:0]]) : 64'(0));
      chk("d_rdata", 64'(bus.d_rdata), exp_dr ? 64'(ref_mem[r_addr[3:0]]) : 64'(0));
      chk("err_spurious", 64'(bus.err_spurious), 64'(0));
      // environment reacts to what the DUT actually did
      if (bus.i_gnt) begin i_done = 1; win_q.push_back(PORT_I); end
      if (bus.d_gnt) begin d_done = 1; win_q.push_back(PORT_D); dg_cyc.push_back(cyc); end
      if (bus.mem_req && bus.mem_gnt) begin
        if (bus.mem_we) mem[bus.mem_addr[3:0]] = bus.mem_wdata;
        else begin rv_next = 1; rd_addr = bus.mem_addr; end
      end
      // model: grant retires writes, schedules read data for the next cycle
      if (exp_req && bus.mem_gnt) begin
        t_act = 0;
        if (t_we) begin
          ref_mem[t_addr[3:0]] = t_wdata; free_at = cyc + 1;
        end else begin
          resp_cyc = cyc + 1; r_own = t_own; r_addr = t_addr; free_at = cyc + 2;
        end
      end
      cyc++;
      tick();
    end
  endtask

  initial begin
    arb_port_t exp_w;
    rst = 1'b1;
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    for (int a = 0; a < 16; a++) begin
      mem[a] = $urandom; ref_mem[a] = mem[a];
    end
    @(negedge clk);
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // single fetch, zero-wait memory
    bus.i_req = 1; bus.i_addr = AW'(30'h10);
    #1 chk("fetch_n_mem_req", 64'(bus.mem_req), 64'(0));
    tick();
    chk("fetch_mem_req", 64'(bus.mem_req), 64'(1));
    chk("fetch_mem_addr", 64'(bus.mem_addr), 64'(30'h10));
    chk("fetch_mem_we", 64'(bus.mem_we), 64'(0));
    bus.mem_gnt = 1;
    #1 chk("fetch_gnt", 64'({bus.i_gnt, bus.d_gnt}), 64'(2'b10));
    tick();
    bus.i_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEADBEEF;
    #1;
    chk("fetch_rvalid", 64'({bus.i_rvalid, bus.d_rvalid}), 64'(2'b10));
    chk("fetch_rdata", 64'(bus.i_rdata), 64'(32'hDEADBEEF));
    chk("fetch_d_rdata", 64'(bus.d_rdata), 64'(0));
    chk("fetch_resp_mem_req", 64'(bus.mem_req), 64'(0));
    tick();
    bus.mem_rvalid = 0;
    chk("fetch_err", 64'(bus.err_spurious), 64'(0));

    // store with the grant held off for three cycles
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = AW'(30'h20); bus.d_wdata = 32'h1234;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("st_mem_req", 64'(bus.mem_req), 64'(1));
      chk("st_mem_we", 64'(bus.mem_we), 64'(1));
      chk("st_mem_addr", 64'(bus.mem_addr), 64'(30'h20));
      chk("st_mem_wdata", 64'(bus.mem_wdata), 64'(32'h1234));
      bus.mem_gnt = (k == 3);
      #1 chk("st_d_gnt", 64'({bus.i_gnt, bus.d_gnt}), 64'((k == 3) ? 2'b01 : 2'b00));
      tick();
    end
    bus.d_req = 0; bus.d_we = 0; bus.mem_gnt = 0;
    #1;
    chk("st_idle_mem_req", 64'(bus.mem_req), 64'(0));
    chk("st_no_rvalid", 64'({bus.i_rvalid, bus.d_rvalid}), 64'(0));
    tick();

    // both ports held continuously: starvation override / round-robin order
    m_last = PORT_D; m_starve = 0; win_q.delete();
    run(40, 100, 100, 0, 100);
    run(16, 0, 0, 0, 100);
    chk("starve_cnt_arbs", 64'(win_q.size() >= 10), 64'(1));
    for (int k = 0; k < 10 && k < win_q.size(); k++) begin
`ifdef RISCV_ARB_RR_EN
      exp_w = (k % 2 == 0) ? PORT_I : PORT_D;
`else
      exp_w = (k % 5 == 4) ? PORT_I : PORT_D;
`endif
      chk($sformatf("starve_order_%0d", k), 64'(win_q[k]), 64'(exp_w));
    end

    // back-to-back loads on D only: one grant every third cycle
    dg_cyc.delete();
    run(30, 0, 100, 0, 100);
    run(16, 0, 0, 0, 100);
    for (int k = 1; k < 6 && k < dg_cyc.size(); k++)
      chk("load_spacing", 64'(dg_cyc[k] - dg_cyc[k-1]), 64'(3));

    // mixed random traffic with random memory stalls
    run(3000, 40, 40, 50, 50);
    run(16, 0, 0, 0, 100);

    // reset while a read response is pending
    bus.mem_gnt = 0; bus.mem_rvalid = 0;
    bus.i_req = 1; bus.i_addr = AW'(3);
    tick();
    bus.mem_gnt = 1;
    tick();
    bus.i_req = 0; bus.mem_gnt = 0; rst = 1;
    tick();
    rst = 0;
    #1 chk_zero("rst_mid");
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hABCD;
    #1;
    chk("late_rvalid", 64'({bus.i_rvalid, bus.d_rvalid}), 64'(0));
    chk("late_rdata", 64'(bus.i_rdata), 64'(0));
    tick();
    bus.mem_rvalid = 0;
    chk("err_set", 64'(bus.err_spurious), 64'(1));
    tick();
    chk("err_sticky", 64'(bus.err_spurious), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
